line_follow_ctrl: RTL and testbench

- Clocked, parametrised rover drive controller.
- Takes an N-wide inductive line-sensor array and a proximity sensor; drives the 4-bit H-bridge command.
- Adds input synchronisation, proximity debounce, last-direction memory, search with timeout, and post-obstacle recovery.
- Sits between the sensor pins and the motor driver pins at rover top level.

---
 rtl/line_follow_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_line_follow_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl
//   Rover drive controller. It steers along an inductive guide line and
//   stops for obstacles. It backs away once an obstacle clears. It searches
//   toward the side where the line was last seen, and gives up after a
//   timeout.
//
// Ports
//   clk        system clock; all logic on the rising edge
//   rst_n      synchronous active-low reset
//   enable     run request; low forces IDLE
//   induct     raw inductive sensors, bit N_SENS-1 leftmost, 1 = line seen
//   proxim     raw proximity sensor, 1 = object near
//   motor_cmd  H-bridge command {L_fwd, L_rev, R_fwd, R_rev}
//   state      current FSM state code
//   obstacle   debounced proximity flag
//   lost       line-lost flag
module line_follow_ctrl #(
  parameter int N_SENS       = 3,
  parameter int DEBOUNCE_CYC = 4,
  parameter int LOST_TIMEOUT = 16,
  parameter int RECOVER_CYC  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_SENS-1:0] induct,
  input  logic              proxim,
  output logic [3:0]        motor_cmd,
  output logic [2:0]        state,
  output logic              obstacle,
  output logic              lost
);

  localparam int unsigned NS    = N_SENS;
  localparam int unsigned C     = (NS - 1) / 2;
  localparam int          CNT_W = $clog2(C + 1);
  localparam int          DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int          ST_W  = $clog2(LOST_TIMEOUT + 1);
  localparam int          RC_W  = $clog2(RECOVER_CYC + 1);

  localparam logic [3:0] CMD_STOP   = 4'b0000;
  localparam logic [3:0] CMD_FWD    = 4'b1010;
  localparam logic [3:0] CMD_SPIN_L = 4'b0110;
  localparam logic [3:0] CMD_SPIN_R = 4'b1001;
  localparam logic [3:0] CMD_REV    = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FOLLOW  = 3'd1,
    S_TURN_L  = 3'd2,
    S_TURN_R  = 3'd3,
    S_HOLD    = 3'd4,
    S_RECOVER = 3'd5,
    S_SEARCH  = 3'd6,
    S_LOST    = 3'd7
  } state_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  // Input synchronisers
  logic [N_SENS-1:0] r_ind_s1;
  logic [N_SENS-1:0] r_ind_s2;
  logic              r_prox_s1;
  logic              r_prox_s2;

  // Debounce
  logic              r_obstacle;
  logic [DB_W-1:0]   r_db_cnt;

  // FSM and registered outputs
  state_t            r_state;
  dir_t              r_dir;
  logic [3:0]        r_motor;
  logic              r_lost;
  logic [ST_W-1:0]   r_srch_cnt;
  logic [RC_W-1:0]   r_rec_cnt;

  // Combinational
  logic [CNT_W-1:0]  w_lc;
  logic [CNT_W-1:0]  w_rc;
  logic              w_none;
  logic              w_all;
  state_t            w_line_state;
  dir_t              w_line_dir;
  state_t            w_state_nxt;
  dir_t              w_dir_nxt;
  logic [3:0]        w_motor_nxt;
  logic              w_srch_expired;
  logic              w_rec_done;

  // Synchronisers and proximity debounce
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ind_s1   <= '0;
      r_ind_s2   <= '0;
      r_prox_s1  <= 1'b0;
      r_prox_s2  <= 1'b0;
      r_obstacle <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_ind_s1  <= induct;
      r_ind_s2  <= r_ind_s1;
      r_prox_s1 <= proxim;
      r_prox_s2 <= r_prox_s1;
      if (r_prox_s2 != r_obstacle) begin
        if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
          r_obstacle <= r_prox_s2;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Line error: sensor counts on each side of the centre sensor
  always_comb begin
    w_lc = '0;
    w_rc = '0;
    for (int unsigned i = 0; i < C; i++) begin
      w_rc = w_rc + CNT_W'(r_ind_s2[i]);
    end
    for (int unsigned i = C + 1; i < NS; i++) begin
      w_lc = w_lc + CNT_W'(r_ind_s2[i]);
    end
    w_none = (r_ind_s2 == '0);
    w_all  = (r_ind_s2 == '1);
  end

  // Line decision shared by the tracking states and by RECOVER once it is done.
  // A cross-line (all sensors on) keeps the current state, except at the end
  // of RECOVER. There the rover is back on the track, so it resumes FOLLOW
  // and does not keep reversing.
  always_comb begin
    w_line_state = r_state;
    w_line_dir   = r_dir;
    if (w_none) begin
      w_line_state = S_SEARCH;
    end else if (w_all) begin
      w_line_state = (r_state == S_RECOVER) ? S_FOLLOW : r_state;
    end else if (w_lc > w_rc) begin
      w_line_state = S_TURN_L;
      w_line_dir   = DIR_LEFT;
    end else if (w_rc > w_lc) begin
      w_line_state = S_TURN_R;
      w_line_dir   = DIR_RIGHT;
    end else begin
      w_line_state = S_FOLLOW;
    end
  end

  assign w_srch_expired = w_none && (r_srch_cnt >= ST_W'(LOST_TIMEOUT - 1));
  assign w_rec_done     = (r_rec_cnt <= RC_W'(1));

  // Next-state logic, in priority order
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else if (r_state == S_LOST) begin
      w_state_nxt = S_LOST;
    end else if (r_obstacle) begin
      w_state_nxt = S_HOLD;
    end else if (r_state == S_HOLD) begin
      w_state_nxt = S_RECOVER;
    end else if (r_state == S_RECOVER && !w_rec_done) begin
      w_state_nxt = S_RECOVER;
    end else if (r_state == S_SEARCH && w_srch_expired) begin
      w_state_nxt = S_LOST;
    end else begin
      w_state_nxt = w_line_state;
      w_dir_nxt   = w_line_dir;
    end
  end

  // Output logic: the command follows the next state and is registered with it
  always_comb begin
    w_motor_nxt = CMD_STOP;
    case (w_state_nxt)
      S_FOLLOW:  w_motor_nxt = CMD_FWD;
      S_TURN_L:  w_motor_nxt = CMD_SPIN_L;
      S_TURN_R:  w_motor_nxt = CMD_SPIN_R;
      S_RECOVER: w_motor_nxt = CMD_REV;
      S_SEARCH:  w_motor_nxt = (w_dir_nxt == DIR_LEFT) ? CMD_SPIN_L : CMD_SPIN_R;
      default:   w_motor_nxt = CMD_STOP;
    endcase
  end

  // State register, timers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_dir      <= DIR_RIGHT;
      r_motor    <= CMD_STOP;
      r_lost     <= 1'b0;
      r_srch_cnt <= '0;
      r_rec_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_motor <= w_motor_nxt;
      // LOST is left only through IDLE, so the flag tracks LOST directly.
      r_lost  <= (w_state_nxt == S_LOST);

      // Search timer: cleared on entry and saturates at the limit. It keeps
      // counting on a cross-line seen during SEARCH.
      if (w_state_nxt == S_SEARCH && r_state == S_SEARCH) begin
        if (r_srch_cnt != ST_W'(LOST_TIMEOUT)) begin
          r_srch_cnt <= r_srch_cnt + ST_W'(1);
        end
      end else begin
        r_srch_cnt <= '0;
      end

      // Recover timer: loaded on entry, then counts down once per cycle
      if (w_state_nxt == S_RECOVER) begin
        if (r_state != S_RECOVER) begin
          r_rec_cnt <= RC_W'(RECOVER_CYC);
        end else begin
          r_rec_cnt <= r_rec_cnt - RC_W'(1);
        end
      end else begin
        r_rec_cnt <= '0;
      end
    end
  end

  assign motor_cmd = r_motor;
  assign state     = r_state;
  assign obstacle  = r_obstacle;
  assign lost      = r_lost;

endmodule

// File: tb/tb_line_follow_ctrl.sv
module tb_line_follow_ctrl;

  localparam int N   = 3;
  localparam int DB  = 4;
  localparam int LT  = 16;
  localparam int RC  = 8;

  localparam int ST_IDLE = 0, ST_FOLLOW = 1, ST_TURN_L = 2, ST_TURN_R = 3,
                 ST_HOLD = 4, ST_RECOVER = 5, ST_SEARCH = 6, ST_LOST = 7;

  logic         clk = 1'b0;
  logic         rst_n_r = 1'b0;
  logic         en_r = 1'b0;
  logic [N-1:0] ind_r = '0;
  logic         prox_r = 1'b0;
  logic [3:0]   motor_o;
  logic [2:0]   state_o;
  logic         obst_o;
  logic         lost_o;

  int n_checks = 0;
  int n_fail   = 0;

  line_follow_ctrl #(
    .N_SENS(N), .DEBOUNCE_CYC(DB), .LOST_TIMEOUT(LT), .RECOVER_CYC(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n_r), .enable(en_r), .induct(ind_r), .proxim(prox_r),
    .motor_cmd(motor_o), .state(state_o), .obstacle(obst_o), .lost(lost_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: behaviour in terms of sensor history, elapsed cycles
  // per state and the transition priority list.
  logic [N-1:0] m_ind_hist [2];
  logic         m_prox_hist[2];
  int m_obst, m_disagree, m_state, m_left, m_srch_spent, m_rec_spent, m_lost, m_motor;

  function automatic int cmd_of(input int st, input int left);
    case (st)
      ST_FOLLOW:  return 'b1010;
      ST_TURN_L:  return 'b0110;
      ST_TURN_R:  return 'b1001;
      ST_RECOVER: return 'b0101;
      ST_SEARCH:  return left ? 'b0110 : 'b1001;
      default:    return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ind_hist[0] = '0; m_ind_hist[1] = '0;
    m_prox_hist[0] = 1'b0; m_prox_hist[1] = 1'b0;
    m_obst = 0; m_disagree = 0; m_state = ST_IDLE; m_left = 0;
    m_srch_spent = 0; m_rec_spent = 0; m_lost = 0; m_motor = 0;
  endtask

  task automatic model_step(input logic rn, input logic en, input logic [N-1:0] ind,
                            input logic px);
    int lc, rc, nst, nleft;
    logic [N-1:0] seen;
    bit none, all1;
    if (!rn) begin
      model_reset();
      return;
    end
    seen = m_ind_hist[1];
    lc = 0; rc = 0;
    for (int i = 0; i < N; i++) begin
      if (i > (N - 1) / 2 && seen[i]) lc++;
      if (i < (N - 1) / 2 && seen[i]) rc++;
    end
    none = (seen == 0);
    all1 = (seen == {N{1'b1}});
    nst = m_state; nleft = m_left;
    if (!en) nst = ST_IDLE;
    else if (m_state == ST_LOST) nst = ST_LOST;
    else if (m_obst != 0) nst = ST_HOLD;
    else if (m_state == ST_HOLD) nst = ST_RECOVER;
    else if (m_state == ST_RECOVER && m_rec_spent + 1 < RC) nst = ST_RECOVER;
    else if (m_state == ST_SEARCH && none && m_srch_spent + 1 >= LT) nst = ST_LOST;
    else if (none) nst = ST_SEARCH;
    else if (all1) nst = (m_state == ST_RECOVER) ? ST_FOLLOW : m_state;
    else if (lc > rc) begin nst = ST_TURN_L; nleft = 1; end
    else if (rc > lc) begin nst = ST_TURN_R; nleft = 0; end
    else nst = ST_FOLLOW;

    m_srch_spent = (nst == ST_SEARCH && m_state == ST_SEARCH) ? m_srch_spent + 1 : 0;
    m_rec_spent  = (nst == ST_RECOVER && m_state == ST_RECOVER) ? m_rec_spent + 1 : 0;
    m_state = nst;
    m_left  = nleft;
    m_lost  = (nst == ST_LOST);
    m_motor = cmd_of(nst, nleft);

    if (int'(m_prox_hist[1]) != m_obst) begin
      if (m_disagree + 1 >= DB) begin
        m_obst = int'(m_prox_hist[1]);
        m_disagree = 0;
      end else m_disagree++;
    end else m_disagree = 0;

    m_ind_hist[1]  = m_ind_hist[0];
    m_ind_hist[0]  = ind;
    m_prox_hist[1] = m_prox_hist[0];
    m_prox_hist[0] = px;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst_n_r, en_r, ind_r, prox_r);
    #1;
    check_eq("state",     32'(state_o), 32'(m_state));
    check_eq("motor_cmd", 32'(motor_o), 32'(m_motor));
    check_eq("obstacle",  32'(obst_o),  32'(m_obst));
    check_eq("lost",      32'(lost_o),  32'(m_lost));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_now(input string tag, input int st, input int mc, input int ob,
                            input int ls);
    check_eq({tag, ".state"}, 32'(state_o), 32'(st));
    check_eq({tag, ".motor"}, 32'(motor_o), 32'(mc));
    check_eq({tag, ".obst"},  32'(obst_o),  32'(ob));
    check_eq({tag, ".lost"},  32'(lost_o),  32'(ls));
  endtask

  initial begin
    model_reset();
    rst_n_r = 1'b0;
    ticks(2);
    expect_now("reset", ST_IDLE, 'b0000, 0, 0);

    rst_n_r = 1'b1; en_r = 1'b1; ind_r = 3'b010;
    ticks(3);
    expect_now("follow", ST_FOLLOW, 'b1010, 0, 0);
    ind_r = 3'b100;
    ticks(3);
    expect_now("turn_l", ST_TURN_L, 'b0110, 0, 0);

    ind_r = 3'b010;
    ticks(3);
    prox_r = 1'b1; ticks(3);
    prox_r = 1'b0; ticks(8);
    expect_now("glitch", ST_FOLLOW, 'b1010, 0, 0);

    prox_r = 1'b1; ticks(6);
    expect_now("obst_set", ST_FOLLOW, 'b1010, 1, 0);
    tick();
    expect_now("hold", ST_HOLD, 'b0000, 1, 0);
    prox_r = 1'b0; ticks(6);
    expect_now("obst_clr", ST_HOLD, 'b0000, 0, 0);
    tick();
    expect_now("recover0", ST_RECOVER, 'b0101, 0, 0);
    ticks(7);
    expect_now("recover7", ST_RECOVER, 'b0101, 0, 0);
    tick();
    expect_now("recover_end", ST_FOLLOW, 'b1010, 0, 0);

    ind_r = 3'b001; ticks(3);
    expect_now("turn_r", ST_TURN_R, 'b1001, 0, 0);
    ind_r = 3'b000; ticks(3);
    expect_now("search", ST_SEARCH, 'b1001, 0, 0);
    ticks(15);
    expect_now("search15", ST_SEARCH, 'b1001, 0, 0);
    tick();
    expect_now("lost", ST_LOST, 'b0000, 0, 1);
    ind_r = 3'b010; ticks(5);
    expect_now("lost_hold", ST_LOST, 'b0000, 0, 1);
    en_r = 1'b0; tick();
    expect_now("idle", ST_IDLE, 'b0000, 0, 0);

    en_r = 1'b1; ind_r = 3'b100; ticks(3);
    expect_now("turn_l2", ST_TURN_L, 'b0110, 0, 0);
    ind_r = 3'b111; ticks(6);
    expect_now("crossline", ST_TURN_L, 'b0110, 0, 0);
    ind_r = 3'b000; ticks(5);
    expect_now("search_l", ST_SEARCH, 'b0110, 0, 0);
    rst_n_r = 1'b0; tick();
    expect_now("mid_reset", ST_IDLE, 'b0000, 0, 0);
    rst_n_r = 1'b1;

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(7) == 0) ind_r = N'($urandom_range(7));
      if ($urandom_range(19) == 0) prox_r = ~prox_r;
      if (en_r) begin
        if ($urandom_range(79) == 0) en_r = 1'b0;
      end else if ($urandom_range(3) == 0) en_r = 1'b1;
      rst_n_r = ($urandom_range(599) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
